systolic_feeder: RTL
====================

# systolic_feeder

Sequences vector reads out of the matrix memory interface and skews the returned N-wide top/left vectors diagonally onto the edges of the NxN systolic array. Sits between memory_interface (upstream, it drives that block's `addr_top`/`addr_left`/`load` and consumes its `data_out_top`/`data_out_left`) and the PE grid (downstream). One `start` pulse streams one full NxN operand pair into the array.

## Interface
- `N`, 2: array dimension; vectors per matrix and lanes per vector.
- `DATA_WIDTH`, 16: element width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a feed; sampled only in IDLE.
- `busy`  out  1  high in LOAD, DRAIN, DONE.
- `done`  out  1  one-cycle pulse after the last element leaves the array edge.
- `mem_addr_top`  out  clog2(N*N)  vector base address to memory_interface `addr_top`.
- `mem_addr_left`  out  clog2(N*N)  same value, to `addr_left`.
- `mem_load`  out  1  to memory_interface `load`. The feeder never drives `store`.
- `mem_data_top[N]`  in  DATA_WIDTH each  from `data_out_top`; valid the cycle after `mem_load`.
- `mem_data_left[N]`  in  DATA_WIDTH each  from `data_out_left`.
- `array_top[N]`  out  DATA_WIDTH each  column-edge inputs of the array.
- `array_left[N]`  out  DATA_WIDTH each  row-edge inputs of the array.
- `array_valid`  out  1  high while any skewed element is on the edges.

Reset values: all outputs 0; state IDLE.

## Operation
- States: IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
- IDLE: outputs 0. `start`=1 -> LOAD, k=0. `start` outside IDLE is ignored, with no queuing.
- LOAD, N cycles: `mem_load`=1, both addresses = k*N, k++ each cycle. After k=N-1 -> DRAIN.
- DRAIN: `mem_load`=0, addresses 0. A counter runs until the last lane empties. The exit condition is given in Timing.
- DONE: 1 cycle. `done`=1, then IDLE.
- Capture: the vector returned for read k is v_k. Lane i of each edge is an i-stage delay behind a common capture register. The edge value is v_k[i] exactly once and 0 at all other times; stale data is never presented.
- Top and left paths are identical and independent. `array_valid` is the OR of per-lane valid bits.
- Width: address = k*N, with max (N-1)*N. memory_interface adds the lane offset i internally, so the highest address touched is N*N-1 and no wrap occurs.
- Reset at any point, mid-LOAD or mid-DRAIN: the next cycle is IDLE and all delay stages and valid bits are cleared. Memory contents are untouched.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE. Cycle c is the c-th cycle after it.
- `mem_load`=1 and address = k*N in cycles 1..N, for k = c-1.
- `mem_data_*` = v_k in cycle k+2, because memory_interface has 1-cycle registered latency.
- `array_top[i]` = v_k_top[i] and `array_left[i]` = v_k_left[i] in cycle 3+k+i.
- `array_valid` is high in cycles 3..2N+1, which is 2N-1 cycles.
- DRAIN covers cycles N+1..2N+1.
- `done` is high in cycle 2N+2, and the block is back in IDLE at cycle 2N+3.
- `busy` is high in cycles 1..2N+2. Back-to-back `start` is accepted at cycle 2N+3 at the earliest.

## Structure
- Shared package `tpu_pkg`: `DATA_W`, `N` defaults, and the feeder state enum (IDLE, LOAD, DRAIN, DONE). memory_interface and the PE grid import the same width constants.
- Sub-module `skew_delay_line #(DEPTH, DATA_WIDTH)`: data plus valid shift register with sync reset that zero-fills. It is instantiated 2N times, with DEPTH=i for lane i. DEPTH=0 is a pass-through of the capture register.
- The FSM, k counter and drain counter live in the top module.

## Test plan
- Basic N=2 feed: top mem {1,2,3,4}, left mem {5,6,7,8}, `start` at cycle 0.
  - Expect `mem_load` in cycles 1-2 with addresses 0, 2.
  - `array_top[0]` = 1,3,0 and `array_top[1]` = 0,2,4 in cycles 3,4,5.
  - `array_left[0]` = 5,7,0 and `array_left[1]` = 0,6,8 in cycles 3,4,5.
  - `done` in cycle 6.
- Reset values: assert `rst` for 2 cycles -> all outputs 0, `busy`=0. Hold `start`=0 for 10 cycles -> `mem_load` never asserted.
- `start` while busy: pulse `start` again at cycles 2 and 5 -> exactly 2 loads, a single `done` at cycle 6, and no second feed.
- Reset mid-DRAIN: `rst` at cycle 4 -> cycle 5 shows all edges 0, `array_valid`=0, `busy`=0, and no `done`. A new `start` then reproduces the basic-feed waveform exactly.
- Back-to-back: `start` at cycle 0 and again at cycle 7 with memory unchanged -> the second feed is identical to the first, shifted by 7 cycles.
- N=4 run with element value = address+1 -> `array_left[3]` = 4,8,12,16 in cycles 6..9, `array_valid` high in cycles 3..9, `done` in cycle 10.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU constants and the operand-feeder state encoding.
// Imported by the feeder, its interface, memory_interface and the PE grid.
package tpu_pkg;

    localparam int DATA_W  = 16;
    localparam int ARRAY_N = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } feed_state_e;

    // Vector base address width; at least one bit for the N=1 array.
    function automatic int addr_w(int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Feeder bus: memory_interface read port plus the skewed array edges.
// master = feeder (drives addr/load/edges), slave = memory + PE grid side.
interface systolic_feeder_if
    import tpu_pkg::*;
#(
    parameter int N          = ARRAY_N,
    parameter int DATA_WIDTH = DATA_W
);
    localparam int AW = addr_w(N);

    logic [AW-1:0]         mem_addr_top;
    logic [AW-1:0]         mem_addr_left;
    logic                  mem_load;
    logic [DATA_WIDTH-1:0] mem_data_top  [N];
    logic [DATA_WIDTH-1:0] mem_data_left [N];
    logic [DATA_WIDTH-1:0] array_top     [N];
    logic [DATA_WIDTH-1:0] array_left    [N];
    logic                  array_valid;

    modport master (
        output mem_addr_top, mem_addr_left, mem_load,
        output array_top, array_left, array_valid,
        input  mem_data_top, mem_data_left
    );

    modport slave (
        input  mem_addr_top, mem_addr_left, mem_load,
        input  array_top, array_left, array_valid,
        output mem_data_top, mem_data_left
    );

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register, sync reset, zero-filled.
// Ports: clk, rst, data_i/valid_i in; data_o/valid_o out (DEPTH=0 passes through).
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst};
        assign data_o    = data_i;
        assign valid_o   = valid_i;
    end else begin : g_shift
        logic [DATA_WIDTH-1:0] d_q [DEPTH];
        logic [DEPTH-1:0]      v_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < DEPTH; j++) d_q[j] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= data_i;
                v_q[0] <= valid_i;
                for (int j = 1; j < DEPTH; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign data_o  = d_q[DEPTH-1];
        assign valid_o = v_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Reads N vectors from memory_interface and skews them onto the array edges.
// Ports: clk, rst, start in; busy, done out; bus = memory read port + array edges.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int N          = ARRAY_N,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    systolic_feeder_if.master bus
);

    localparam int AW = addr_w(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);
    localparam logic [CW-1:0] D_LAST = CW'(N);

    feed_state_e   state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr;

    // Memory data arrives one cycle after load; ld_q marks it valid.
    logic                  ld_q;
    logic                  cap_v_q;
    logic [DATA_WIDTH-1:0] cap_top_q  [N];
    logic [DATA_WIDTH-1:0] cap_left_q [N];
    logic [N-1:0]          top_v, left_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            // Runs N+1 cycles: last lane empties N-1 cycles after capture.
            DRAIN: begin
                if (cnt_q == D_LAST) state_d = DONE;
                else                 cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_load      = (state_q == LOAD);
    assign addr              = AW'(int'(k_q) * N);
    assign bus.mem_addr_top  = bus.mem_load ? addr : '0;
    assign bus.mem_addr_left = bus.mem_load ? addr : '0;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);

    // Capture zero-fills when no read returned, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q    <= 1'b0;
            cap_v_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cap_top_q[i]  <= '0;
                cap_left_q[i] <= '0;
            end
        end else begin
            ld_q    <= bus.mem_load;
            cap_v_q <= ld_q;
            for (int i = 0; i < N; i++) begin
                cap_top_q[i]  <= ld_q ? bus.mem_data_top[i]  : '0;
                cap_left_q[i] <= ld_q ? bus.mem_data_left[i] : '0;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH      (i),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_top (
            .clk     (clk),
            .rst     (rst),
            .data_i  (cap_top_q[i]),
            .valid_i (cap_v_q),
            .data_o  (bus.array_top[i]),
            .valid_o (top_v[i])
        );

        skew_delay_line #(
            .DEPTH      (i),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_left (
            .clk     (clk),
            .rst     (rst),
            .data_i  (cap_left_q[i]),
            .valid_i (cap_v_q),
            .data_o  (bus.array_left[i]),
            .valid_o (left_v[i])
        );
    end

    assign bus.array_valid = |{top_v, left_v};

endmodule
